// File: rtl/dtp_pkg.sv
// Shared types and helpers for the dtp array controller.
package dtp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dtp_state_e;

  localparam int DEF_RES_WIDTH = 16;

  // Channel-id tag width; a single channel still gets a 1-bit tag.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dtp_array_ctrl_if.sv
// Host, core and result-FIFO signals of the dtp array controller.
interface dtp_array_ctrl_if #(
  parameter int NUM_DTP   = 4,
  parameter int RES_WIDTH = dtp_pkg::DEF_RES_WIDTH,
  parameter int CNT_WIDTH = 16
);
  import dtp_pkg::*;
  localparam int CH_W = ch_w(NUM_DTP);

  logic                                i_start;
  logic                                i_end;
  logic [NUM_DTP-1:0]                  i_ch_en;
  logic [NUM_DTP-1:0]                  o_dtp_start;
  logic [NUM_DTP-1:0]                  o_dtp_end;
  logic [NUM_DTP-1:0]                  i_dtp_fin;
  logic [NUM_DTP-1:0]                  i_ch_res_we;
  logic [NUM_DTP-1:0][RES_WIDTH-1:0]   i_ch_res_dout;
  logic [NUM_DTP-1:0]                  o_ch_res_full;
  logic                                i_res_fifo_is_full;
  logic                                o_res_fifo_we;
  logic [CH_W+RES_WIDTH-1:0]           o_res_fifo_dout;
  logic                                o_fin;
  logic                                o_busy;
  logic [CNT_WIDTH-1:0]                o_res_cnt;
  logic                                o_err_ovf;

  modport slave (
    input  i_start, i_end, i_ch_en, i_dtp_fin, i_ch_res_we, i_ch_res_dout, i_res_fifo_is_full,
    output o_dtp_start, o_dtp_end, o_ch_res_full, o_res_fifo_we, o_res_fifo_dout,
           o_fin, o_busy, o_res_cnt, o_err_ovf
  );

  modport master (
    output i_start, i_end, i_ch_en, i_dtp_fin, i_ch_res_we, i_ch_res_dout, i_res_fifo_is_full,
    input  o_dtp_start, o_dtp_end, o_ch_res_full, o_res_fifo_we, o_res_fifo_dout,
           o_fin, o_busy, o_res_cnt, o_err_ovf
  );

endinterface

// File: rtl/dtp_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted id.
module dtp_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = dtp_pkg::ch_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);
  logic [IW-1:0] ptr;

  // First requester after ptr (wrapping) wins; nothing granted while disabled.
  always_comb begin
    int          idx;
    logic [IW-1:0] sel;
    logic        hit;
    gnt    = '0;
    gnt_id = '0;
    hit    = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = IW'(idx);
      if (en && !hit && req[sel]) begin
        hit      = 1'b1;
        gnt[sel] = 1'b1;
        gnt_id   = sel;
      end
    end
  end

  // Remember the last winner so it becomes lowest priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= IW'(N - 1);
    else if (|gnt) ptr <= gnt_id;
  end

endmodule

// File: rtl/dtp_array_ctrl.sv
// Controller for NUM_DTP parallel dtp cores: start/end broadcast,
// per-channel result buffering and round-robin merge into one FIFO.
module dtp_array_ctrl #(
  parameter int NUM_DTP   = 4,
  parameter int RES_WIDTH = dtp_pkg::DEF_RES_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  dtp_array_ctrl_if.slave bus
);
  import dtp_pkg::*;
  localparam int CH_W = ch_w(NUM_DTP);

  dtp_state_e                        state, state_nx;
  logic [NUM_DTP-1:0]                mask, act, vld, gnt, cap;
  logic [NUM_DTP-1:0][RES_WIDTH-1:0] dat;
  logic [CH_W-1:0]                   gnt_id;
  logic [NUM_DTP-1:0]                start_d, end_d;
  logic                              fin_d, start_ok, drained, ovf_hit;
  logic [CNT_WIDTH-1:0]              res_cnt;
  logic                              err_ovf;

  // Writes are only honoured from enabled channels while a run is active.
  assign act      = (state != IDLE) ? mask : '0;
  assign start_ok = bus.i_start && (|bus.i_ch_en);
  assign cap      = bus.i_ch_res_we & act & (~vld | gnt);
  assign ovf_hit  = |(bus.i_ch_res_we & act & vld & ~gnt);
  assign drained  = (vld == '0) && ((bus.i_ch_res_we & mask) == '0);

  dtp_rr_arbiter #(.N(NUM_DTP), .IW(CH_W)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (vld),
    .en     (!bus.i_res_fifo_is_full),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign bus.o_ch_res_full   = vld & ~gnt;
  assign bus.o_res_fifo_we   = |gnt;
  assign bus.o_res_fifo_dout = (|gnt) ? {gnt_id, dat[gnt_id]} : '0;
  assign bus.o_busy          = (state != IDLE);
  assign bus.o_res_cnt       = res_cnt;
  assign bus.o_err_ovf       = err_ovf;

  // One-entry buffer per channel; a capture on a granted slot refills it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      dat <= '0;
    end else begin
      for (int c = 0; c < NUM_DTP; c++) begin
        if (cap[c]) begin
          vld[c] <= 1'b1;
          dat[c] <= bus.i_ch_res_dout[c];
        end else if (gnt[c]) begin
          vld[c] <= 1'b0;
        end
      end
    end
  end

  // Run mask, result counter (saturating) and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask    <= '0;
      res_cnt <= '0;
      err_ovf <= 1'b0;
    end else if (state == IDLE && start_ok) begin
      mask    <= bus.i_ch_en;
      res_cnt <= '0;
      err_ovf <= 1'b0;
    end else begin
      if ((|gnt) && !(&res_cnt)) res_cnt <= res_cnt + 1'b1;
      if (ovf_hit)               err_ovf <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = RUN;
      RUN:     if (bus.i_end && ((bus.i_dtp_fin & mask) == mask)) state_nx = DRAIN;
      DRAIN:   if (drained) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs, computed one cycle ahead and registered below.
  always_comb begin
    start_d = '0;
    end_d   = '0;
    fin_d   = 1'b0;
    case (state)
      IDLE:    if (bus.i_start) begin
                 if (|bus.i_ch_en) start_d = bus.i_ch_en;
                 else              fin_d   = 1'b1;
               end
      RUN:     end_d = mask & {NUM_DTP{bus.i_end}};
      DRAIN:   if (drained) fin_d = 1'b1;
               else         end_d = mask;
      default: ;
    endcase
  end

  // Registered core strobes and finish pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_dtp_start <= '0;
      bus.o_dtp_end   <= '0;
      bus.o_fin       <= 1'b0;
    end else begin
      bus.o_dtp_start <= start_d;
      bus.o_dtp_end   <= end_d;
      bus.o_fin       <= fin_d;
    end
  end

endmodule

// File: tb/tb_dtp_array_ctrl.sv
// Directed bench for dtp_array_ctrl with a per-cycle behavioural model.
module tb_dtp_array_ctrl;
  localparam int N    = 4;
  localparam int RW   = 16;
  localparam int CNTW = 16;
  localparam int CHW  = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dtp_array_ctrl_if #(.NUM_DTP(N), .RES_WIDTH(RW), .CNT_WIDTH(CNTW)) bus ();

  dtp_array_ctrl #(.NUM_DTP(N), .RES_WIDTH(RW), .CNT_WIDTH(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              m_phase;  // 0 idle, 1 running, 2 draining
  logic [N-1:0]    m_mask, m_v, m_start, m_end;
  logic [RW-1:0]   m_d [N];
  int              m_ptr, m_cnt;
  bit              m_ovf, m_fin;

  int              log_id[$];
  logic [RW-1:0]   log_d[$];
  int              fin_cnt = 0;
  int              cyc = 0;
  int              last_we_cyc = 0;
  int              last_fin_cyc = 0;

  always @(negedge clk) begin
    int g, c;
    bit empty;
    logic [N-1:0] ef;
    logic [CHW+RW-1:0] ed;
    cyc++;
    if (bus.o_fin) begin fin_cnt++; last_fin_cyc = cyc; end
    if (bus.o_res_fifo_we) begin
      log_id.push_back(int'(bus.o_res_fifo_dout[CHW+RW-1:RW]));
      log_d.push_back(bus.o_res_fifo_dout[RW-1:0]);
      last_we_cyc = cyc;
    end
    if (!rst_n) begin
      m_phase = 0; m_mask = '0; m_v = '0; m_start = '0; m_end = '0;
      m_ptr = N - 1; m_cnt = 0; m_ovf = 0; m_fin = 0;
      for (int k = 0; k < N; k++) m_d[k] = '0;
      chk("reset_outputs",
          {bus.o_busy, bus.o_fin, bus.o_res_fifo_we, bus.o_err_ovf, bus.o_dtp_start,
           bus.o_dtp_end, bus.o_ch_res_full, bus.o_res_cnt, bus.o_res_fifo_dout}, '0);
    end else begin
      // which buffered word goes to the FIFO this cycle
      g = -1;
      if (!bus.i_res_fifo_is_full)
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (g < 0 && m_v[c]) g = c;
        end
      for (int k = 0; k < N; k++) ef[k] = m_v[k] && (k != g);
      ed = (g >= 0) ? {CHW'(g), m_d[g]} : '0;

      chk("fifo_we",   bus.o_res_fifo_we, g >= 0);
      chk("fifo_dout", bus.o_res_fifo_dout, ed);
      chk("ch_full",   bus.o_ch_res_full, ef);
      chk("busy",      bus.o_busy, m_phase != 0);
      chk("fin",       bus.o_fin, m_fin);
      chk("dtp_start", bus.o_dtp_start, m_start);
      chk("dtp_end",   bus.o_dtp_end, m_end);
      chk("res_cnt",   bus.o_res_cnt, m_cnt);
      chk("err_ovf",   bus.o_err_ovf, m_ovf);

      // advance the model to the state after the coming edge
      empty = (m_v == '0);
      if (g >= 0) m_v[g] = 1'b0;
      for (int k = 0; k < N; k++)
        if (bus.i_ch_res_we[k] && m_phase != 0 && m_mask[k]) begin
          if (ef[k]) m_ovf = 1;
          else begin m_v[k] = 1'b1; m_d[k] = bus.i_ch_res_dout[k]; end
        end
      if (g >= 0) begin
        m_ptr = g;
        if (m_cnt < (1 << CNTW) - 1) m_cnt++;
      end
      m_fin = 0; m_start = '0;
      case (m_phase)
        0: begin
          m_end = '0;
          if (bus.i_start) begin
            if (bus.i_ch_en != '0) begin
              m_mask = bus.i_ch_en; m_cnt = 0; m_ovf = 0;
              m_start = bus.i_ch_en; m_phase = 1;
            end else m_fin = 1;
          end
        end
        1: begin
          m_end = bus.i_end ? m_mask : '0;
          if (bus.i_end && ((bus.i_dtp_fin & m_mask) == m_mask)) m_phase = 2;
        end
        default: begin
          if (empty && ((bus.i_ch_res_we & m_mask) == '0)) begin
            m_fin = 1; m_phase = 0; m_end = '0;
          end else m_end = m_mask;
        end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [N-1:0] en);
    bus.i_ch_en = en;
    bus.i_start = 1'b1;
    tick(1);
    bus.i_start = 1'b0;
  endtask

  task automatic wr(input logic [N-1:0] m, input logic [RW-1:0] base);
    for (int c = 0; c < N; c++) bus.i_ch_res_dout[c] = RW'(c * 256) + base;
    bus.i_ch_res_we = m;
    tick(1);
    bus.i_ch_res_we = '0;
  endtask

  task automatic chk_ids(input string nm, input int base, input int e0, input int e1,
                         input int e2, input int e3);
    int exp [4];
    exp = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++)
      chk(nm, (base + k < log_id.size()) ? log_id[base + k] : -1, exp[k]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n0, fb, ch2;
    bus.i_start = 0; bus.i_end = 0; bus.i_ch_en = '0; bus.i_dtp_fin = '0;
    bus.i_ch_res_we = '0; bus.i_ch_res_dout = '0; bus.i_res_fifo_is_full = 0;
    tick(2);
    rst_n = 1'b1;
    chk("reset_busy", bus.o_busy, 0);
    tick(1);

    // empty mask: finish pulse straight away, stay idle
    do_start('0);
    chk("zmask_fin", bus.o_fin, 1);
    chk("zmask_busy", bus.o_busy, 0);
    tick(1);
    chk("zmask_fin_drop", bus.o_fin, 0);

    // mask 1011, three words per core, channel 2 also writes but is ignored
    fb = fin_cnt;
    do_start(4'b1011);
    chk("t1_start", bus.o_dtp_start, 4'b1011);
    tick(1);
    chk("t1_start_pulse", bus.o_dtp_start, 4'b0000);
    for (int b = 1; b <= 3; b++) begin wr(4'hF, RW'(b)); tick(4); end
    bus.i_end = 1; bus.i_dtp_fin = 4'b1011;
    tick(4);
    bus.i_end = 0; bus.i_dtp_fin = '0;
    chk("t1_nwrites", log_id.size(), 9);
    chk("t1_id0", log_id[0], 0);
    chk("t1_id1", log_id[1], 1);
    chk("t1_id2", log_id[2], 3);
    chk("t1_data2", log_d[2], 16'h0301);
    ch2 = 0;
    foreach (log_id[k]) if (log_id[k] == 2) ch2++;
    chk("t1_no_ch2", ch2, 0);
    chk("t1_cnt", bus.o_res_cnt, 9);
    chk("t1_fin_once", fin_cnt - fb, 1);
    chk("t1_idle", bus.o_busy, 0);

    // all four write together, twice
    do_start(4'hF);
    tick(1);
    n0 = log_id.size();
    wr(4'hF, 16'h10); tick(5);
    wr(4'hF, 16'h20); tick(5);
    chk_ids("t2_burst1", n0, 0, 1, 2, 3);
    chk_ids("t2_burst2", n0 + 4, 0, 1, 2, 3);
    wr(4'b0010, 16'h30); tick(3);

    // FIFO full for ten cycles with every buffer valid
    bus.i_res_fifo_is_full = 1;
    n0 = log_id.size();
    wr(4'hF, 16'h40); tick(4);
    chk("t3_we_held", bus.o_res_fifo_we, 0);
    chk("t3_full", bus.o_ch_res_full, 4'hF);
    tick(5);
    chk("t3_no_writes", log_id.size(), n0);
    bus.i_res_fifo_is_full = 0;
    tick(6);
    chk_ids("t3_order", n0, 2, 3, 0, 1);

    // core 1 overruns its buffer while the FIFO is full
    bus.i_res_fifo_is_full = 1;
    bus.i_ch_res_dout[1] = 16'hAAAA; bus.i_ch_res_we = 4'b0010;
    tick(1);
    bus.i_ch_res_dout[1] = 16'hBBBB;
    tick(1);
    bus.i_ch_res_we = '0;
    chk("t4_ovf", bus.o_err_ovf, 1);
    n0 = log_id.size();
    bus.i_res_fifo_is_full = 0;
    tick(3);
    chk("t4_one_word", log_id.size(), n0 + 1);
    chk("t4_id", (n0 < log_id.size()) ? log_id[n0] : -1, 1);
    chk("t4_kept", (n0 < log_d.size()) ? log_d[n0] : 16'h0, 16'hAAAA);
    bus.i_end = 1; bus.i_dtp_fin = 4'hF;
    tick(4);
    bus.i_end = 0; bus.i_dtp_fin = '0;
    chk("t4_idle", bus.o_busy, 0);
    chk("t4_ovf_sticky", bus.o_err_ovf, 1);

    // new start clears the flag; core 3 finishes late with a word buffered
    do_start(4'hF);
    chk("t5_ovf_clr", bus.o_err_ovf, 0);
    chk("t5_cnt_clr", bus.o_res_cnt, 0);
    fb = fin_cnt;
    bus.i_end = 1; bus.i_dtp_fin = 4'b0111; bus.i_res_fifo_is_full = 1;
    bus.i_ch_res_dout[3] = 16'h3333; bus.i_ch_res_we = 4'b1000;
    tick(1);
    bus.i_ch_res_we = '0;
    tick(5);
    chk("t5_still_run", bus.o_busy, 1);
    chk("t5_no_fin", fin_cnt, fb);
    bus.i_dtp_fin = 4'hF;
    tick(3);
    chk("t5_wait_drain", fin_cnt, fb);
    chk("t5_end_held", bus.o_dtp_end, 4'hF);
    bus.i_res_fifo_is_full = 0;
    tick(4);
    chk("t5_fin", fin_cnt, fb + 1);
    chk("t5_last_id", (log_id.size() > 0) ? log_id[$] : -1, 3);
    chk("t5_last_data", (log_d.size() > 0) ? log_d[$] : 16'h0, 16'h3333);
    chk("t5_fin_after_write", last_fin_cyc - last_we_cyc, 2);
    bus.i_end = 0; bus.i_dtp_fin = '0;
    tick(1);

    // reset in the middle of a run with full buffers
    do_start(4'hF);
    tick(1);
    bus.i_end = 1; bus.i_res_fifo_is_full = 1;
    wr(4'hF, 16'h60); tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", bus.o_busy, 0);
    chk("t6_full", bus.o_ch_res_full, 0);
    chk("t6_end", bus.o_dtp_end, 0);
    chk("t6_we", bus.o_res_fifo_we, 0);
    fb = fin_cnt;
    n0 = log_id.size();
    bus.i_end = 0; bus.i_res_fifo_is_full = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(6);
    chk("t6_no_fin", fin_cnt, fb);
    chk("t6_no_write", log_id.size(), n0);
    chk("t6_idle", bus.o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dtp_array_ctrl.md
Name: dtp_array_ctrl

Overview:
- Multi-channel controller for NUM_DTP decision-tree processor (dtp) cores running in parallel on the same sample stream.
- Broadcasts start/end to an enabled subset of cores and buffers each core's result words.
- Merges those words, round-robin and tagged with channel id, into the single shared result FIFO.
- Raises one aggregate finish pulse once every enabled core has finished and all buffers are drained.

Parameters:
- NUM_DTP, 4, number of dtp channels (2..16).
- RES_WIDTH, 16, result word width per core.
- CH_W, $clog2(NUM_DTP), channel-id tag width (derived; not overridden).
- CNT_WIDTH, 16, width of written-result counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle run request.
- i_end  in  1  level; host declares end of sample stream.
- i_ch_en  in  NUM_DTP  channel enable mask, sampled on accepted i_start.
- o_dtp_start  out  NUM_DTP  per-core start pulse.
- o_dtp_end  out  NUM_DTP  per-core end level.
- i_dtp_fin  in  NUM_DTP  per-core finish level.
- i_ch_res_we  in  NUM_DTP  per-core result write strobe.
- i_ch_res_dout  in  NUM_DTP*RES_WIDTH  per-core result words, channel i at bits [i*RES_WIDTH +: RES_WIDTH].
- o_ch_res_full  out  NUM_DTP  per-core back-pressure.
- i_res_fifo_is_full  in  1  shared FIFO full.
- o_res_fifo_we  out  1  shared FIFO write.
- o_res_fifo_dout  out  CH_W+RES_WIDTH  {channel id, result}.
- o_fin  out  1  aggregate finish pulse.
- o_busy  out  1  high while not IDLE.
- o_res_cnt  out  CNT_WIDTH  results written this run.
- o_err_ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM=IDLE, buffers empty, mask=0, RR pointer=NUM_DTP-1.
- FSM states: IDLE, RUN, DRAIN.
- IDLE + i_start with i_ch_en!=0 (cycle t):
  - Latch mask, clear o_res_cnt and o_err_ovf.
  - o_dtp_start=mask for exactly cycle t+1; FSM=RUN at t+1.
- IDLE + i_start with i_ch_en==0: o_fin pulses at t+1; FSM stays IDLE.
- i_start outside IDLE is ignored.
- RUN:
  - o_dtp_end = mask & {NUM_DTP{i_end}}, registered, 1-cycle latency.
  - When i_end=1 and (i_dtp_fin & mask)==mask: go to DRAIN.
- DRAIN:
  - o_dtp_end held = mask.
  - When all buffers are empty and no write is in flight: o_fin=1 for one cycle, FSM=IDLE.
  - o_dtp_end returns to 0 in the same cycle o_fin is asserted.
- Per-channel 1-entry buffer (valid + data):
  - i_ch_res_we[i] with buffer free or being granted this cycle: capture at next edge.
  - o_ch_res_full[i] = valid[i] & ~grant[i] (combinational).
  - Write while o_ch_res_full[i]=1: word dropped, o_err_ovf set (sticky until next accepted start).
  - Writes from channels outside mask are ignored and do not set the error flag.
- Arbiter:
  - Combinational round-robin over valid[], starting at pointer+1 and wrapping NUM_DTP-1 -> 0.
  - grant only when i_res_fifo_is_full=0.
  - o_res_fifo_we = |grant (combinational).
  - o_res_fifo_dout = {granted id, buffer data}.
  - Pointer updates to the granted id on grant.
  - Minimum latency: core write at t -> o_res_fifo_we at t+1.
- o_res_cnt increments per o_res_fifo_we; saturates at all-ones.
- Simultaneous events:
  - Capture and grant on the same channel in one cycle: new word replaces the drained one, valid stays 1.
  - FIFO full: all buffers hold, grants 0, cores see full.
- Reset mid-run: immediate return to IDLE; buffered words discarded; no o_fin.

Decomposition:
- Package dtp_pkg: FSM state enum (IDLE, RUN, DRAIN), CH_W derivation function, default RES_WIDTH.
- One sub-module, dtp_rr_arbiter, parameterised by N: req[N], enable -> one-hot grant[N], grant id, internal pointer.

Test Plan:
- Start with mask=4'b1011, each enabled core writes 3 words, end, all fin -> o_dtp_start=4'b1011 for one cycle; 9 FIFO writes, channel 2 never appears; o_res_cnt=9; one o_fin pulse.
- All 4 channels write in the same cycle, FIFO not full -> writes on 4 consecutive cycles with ids 0,1,2,3; a second burst yields ids 0,1,2,3 again.
- FIFO full held 10 cycles with all buffers valid -> o_res_fifo_we=0, o_ch_res_full=4'hF; once released, ordering continues from the pointer.
- Core 1 writes twice back-to-back while FIFO is full -> o_err_ovf=1, first word kept; second start clears the flag.
- i_end with core 3 fin low -> FSM stays RUN; core 3 fin rises -> DRAIN, o_fin only after its buffered word is written.
- Reset asserted in RUN with buffers valid -> all outputs 0 asynchronously; no o_fin and no FIFO write after release.
